// File: rtl/full_st1_data_src_pkg.sv
// Shared types for the stage_1 data stream source: word format, launch config and FSM states.
// FULL_ST1_DATA_SRC_LAST_EN adds a last-word flag to the buffered stream word.
package full_st1_data_src_pkg;

    localparam int DEPTH_DEF  = 128;
    localparam int ADDR_W_DEF = 7;

    typedef logic [31:0] float_24_8;

    // "repeat" is a keyword, hence the plural field name.
    typedef struct packed {
        logic [ADDR_W_DEF:0] length;
        logic [7:0]          repeats;
    } full_st1_data_src_cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        FLUSH
    } full_st1_data_src_state_t;

    // One stream word with the sideband flags that travel alongside it.
    typedef struct packed {
        float_24_8 data;
        logic      fst;
`ifdef FULL_ST1_DATA_SRC_LAST_EN
        logic      lst;
`endif
    } st1_word_t;

endpackage

// File: rtl/full_st1_data_src_mem.sv
// DEPTH x 32 vector buffer: one write port, one synchronous read port with 1-cycle latency.
module full_st1_data_src_mem
    import full_st1_data_src_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  float_24_8         wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output float_24_8         rd_data
);

    float_24_8 mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM; only control state is reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/full_st1_data_src.sv
// Replays a host-loaded vector cfg_repeat+1 times on the stage_1_data vld/rdy/fst interface.
// Define FULL_ST1_DATA_SRC_LAST_EN to add the stage_1_data_lst output.
module full_st1_data_src
    import full_st1_data_src_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W:0]   cfg_length,
    input  logic [7:0]        cfg_repeat,
    input  logic              start,
    output float_24_8         stage_1_data,
    output logic              stage_1_data_vld,
    output logic              stage_1_data_fst,
`ifdef FULL_ST1_DATA_SRC_LAST_EN
    output logic              stage_1_data_lst,
`endif
    input  logic              stage_1_data_rdy,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    full_st1_data_src_state_t state_q;
    full_st1_data_src_cfg_t   cfg_q;
    logic [ADDR_W:0]          word_q;
    logic [7:0]               pass_q;
    logic                     fetched_q;
    logic                     busy_q, done_q, wr_err_q;

    st1_word_t                out_q, skid_q, rd_word;
    logic                     out_vld_q, skid_vld_q, rd_vld_q, rd_fst_q;
`ifdef FULL_ST1_DATA_SRC_LAST_EN
    logic                     rd_lst_q;
`endif
    float_24_8                mem_rdata;

    logic                     start_ok, xfer, final_xfer;
    logic                     rd_en, fetch_fst, fetch_lst, last_fetch;
    logic [ADDR_W-1:0]        rd_addr;
    logic [1:0]               occ_next;

    full_st1_data_src_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .wr_en   (wr_en && !busy_q),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (mem_rdata)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        start_ok   = start && (cfg_length != '0) && (cfg_length <= DEPTH_L);
        xfer       = out_vld_q && stage_1_data_rdy;
        // Slots still committed after this cycle: a read issued now needs one free next cycle.
        occ_next   = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_q} - {1'b0, xfer};
        rd_en      = 1'b0;
        rd_addr    = '0;
        fetch_fst  = 1'b0;
        fetch_lst  = 1'b0;
        last_fetch = 1'b0;
        case (state_q)
            IDLE: begin
                // Word 0 is read on the launch edge so it is on the output two cycles after start.
                if (start_ok) begin
                    rd_en      = 1'b1;
                    fetch_fst  = 1'b1;
                    fetch_lst  = (cfg_length == LEN_ONE);
                    last_fetch = fetch_lst && (cfg_repeat == 8'd0);
                end
            end
            PRIME, STREAM: begin
                rd_en      = !fetched_q && (occ_next < 2'd2);
                rd_addr    = word_q[ADDR_W-1:0];
                fetch_fst  = (word_q == '0);
                fetch_lst  = (word_q == cfg_q.length - LEN_ONE);
                last_fetch = fetch_lst && (pass_q == cfg_q.repeats);
            end
            default: ;
        endcase
        final_xfer = (state_q == FLUSH) && xfer && !skid_vld_q && !rd_vld_q;

        rd_word      = '0;
        rd_word.data = mem_rdata;
        rd_word.fst  = rd_fst_q;
`ifdef FULL_ST1_DATA_SRC_LAST_EN
        rd_word.lst  = rd_lst_q;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            word_q    <= '0;
            pass_q    <= '0;
            fetched_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            wr_err_q <= wr_en && busy_q;
            if (rd_en && (state_q != IDLE)) begin
                if (fetch_lst) begin
                    word_q <= '0;
                    pass_q <= pass_q + 8'd1;
                end else begin
                    word_q <= word_q + LEN_ONE;
                end
                fetched_q <= last_fetch;
            end
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        cfg_q.length  <= cfg_length;
                        cfg_q.repeats <= cfg_repeat;
                        word_q        <= (cfg_length == LEN_ONE) ? '0 : LEN_ONE;
                        pass_q        <= (cfg_length == LEN_ONE) ? 8'd1 : 8'd0;
                        fetched_q     <= last_fetch;
                        busy_q        <= 1'b1;
                        state_q       <= PRIME;
                    end
                end
                PRIME:  state_q <= (fetched_q || (rd_en && last_fetch)) ? FLUSH : STREAM;
                STREAM: if (rd_en && last_fetch) state_q <= FLUSH;
                FLUSH: begin
                    if (final_xfer) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output register backed by a skid entry; the skid always drains into the output first.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_fst_q   <= 1'b0;
`ifdef FULL_ST1_DATA_SRC_LAST_EN
            rd_lst_q   <= 1'b0;
`endif
        end else begin
            rd_vld_q <= rd_en;
            rd_fst_q <= fetch_fst;
`ifdef FULL_ST1_DATA_SRC_LAST_EN
            rd_lst_q <= fetch_lst;
`endif
            if (xfer) begin
                if (skid_vld_q) begin
                    out_q <= skid_q;
                    if (rd_vld_q) skid_q <= rd_word;
                    else          skid_vld_q <= 1'b0;
                end else if (rd_vld_q) begin
                    out_q <= rd_word;
                end else begin
                    out_vld_q <= 1'b0;
                end
            end else if (rd_vld_q) begin
                if (!out_vld_q) begin
                    out_q     <= rd_word;
                    out_vld_q <= 1'b1;
                end else begin
                    skid_q     <= rd_word;
                    skid_vld_q <= 1'b1;
                end
            end
        end
    end

    assign stage_1_data     = out_q.data;
    assign stage_1_data_vld = out_vld_q;
    assign stage_1_data_fst = out_q.fst;
`ifdef FULL_ST1_DATA_SRC_LAST_EN
    assign stage_1_data_lst = out_q.lst;
`endif
    assign busy             = busy_q;
    assign done             = done_q;
    assign wr_err           = wr_err_q;

endmodule

// File: tb/tb_full_st1_data_src.sv
// Directed self-checking bench for full_st1_data_src (default build and FULL_ST1_DATA_SRC_LAST_EN).
module tb_full_st1_data_src;
    import full_st1_data_src_pkg::*;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam logic [31:0] BASE = 32'h3F80_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   cfg_length;
    logic [7:0]        cfg_repeat;
    logic              start;
    float_24_8         stage_1_data;
    logic              vld, fst, rdy, busy, done, wr_err;
`ifdef FULL_ST1_DATA_SRC_LAST_EN
    logic              lst;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    full_st1_data_src #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .cfg_length       (cfg_length),
        .cfg_repeat       (cfg_repeat),
        .start            (start),
        .stage_1_data     (stage_1_data),
        .stage_1_data_vld (vld),
        .stage_1_data_fst (fst),
`ifdef FULL_ST1_DATA_SRC_LAST_EN
        .stage_1_data_lst (lst),
`endif
        .stage_1_data_rdy (rdy),
        .busy             (busy),
        .done             (done),
        .wr_err           (wr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // Start pulse in cycle t; returns in cycle t+1.
    task automatic launch(input int len, input int rep);
        cfg_length = (ADDR_W+1)'(len);
        cfg_repeat = 8'(rep);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Drives rdy, checks every transfer and every stall, then checks the done cycle.
    task automatic collect(input string tag, input int len, input int rep, input bit toggle,
                           output int first_c, output int last_c);
        int          n      = 0;
        int          exp_n  = len * (rep + 1);
        int          dones  = 0;
        int          cyc    = 0;
        bit          held   = 1'b0;
        logic [31:0] hd     = '0;
        logic        hf     = 1'b0;
        first_c = -1;
        last_c  = -1;
        while (n < exp_n && cyc < 400) begin
            rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (done) dones++;
            if (held) begin
                check({tag, " stall data"}, stage_1_data, hd);
                check({tag, " stall fst"}, 32'(fst), 32'(hf));
            end
            if (vld && rdy) begin
                check({tag, " data"}, stage_1_data, BASE + 32'(n % len));
                check({tag, " fst"}, 32'(fst), 32'((n % len) == 0));
`ifdef FULL_ST1_DATA_SRC_LAST_EN
                check({tag, " lst"}, 32'(lst), 32'((n % len) == len - 1));
`endif
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                n++;
                held = 1'b0;
            end else begin
                held = vld;
                hd   = stage_1_data;
                hf   = fst;
            end
            tick();
            cyc++;
        end
        check({tag, " transfers"}, 32'(n), 32'(exp_n));
        check({tag, " done after last"}, 32'(done), 32'd1);
        check({tag, " busy low with done"}, 32'(busy), 32'd0);
        check({tag, " vld low after last"}, 32'(vld), 32'd0);
        if (done) dones++;
        repeat (3) begin
            tick();
            if (done) dones++;
        end
        check({tag, " done count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        int fc, lc;
        logic seen;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cfg_length = '0; cfg_repeat = '0; start = 1'b0; rdy = 1'b0;
        repeat (3) tick();
        check("reset vld", 32'(vld), 32'd0);
        check("reset data", stage_1_data, 32'd0);
        check("reset fst", 32'(fst), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset wr_err", 32'(wr_err), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) write_word(i, BASE + 32'(i));

        // Single pass, rdy high: first word two cycles after start, last at t+5.
        rdy = 1'b1;
        launch(4, 0);
        check("t1 vld at t+1", 32'(vld), 32'd0);
        check("t1 busy at t+1", 32'(busy), 32'd1);
        collect("t1", 4, 0, 1'b0, fc, lc);
        check("t1 first xfer at t+2", 32'(fc), 32'd1);
        check("t1 last xfer at t+5", 32'(lc), 32'd4);

        // Three passes under alternating backpressure.
        launch(4, 2);
        collect("t2", 4, 2, 1'b1, fc, lc);

        // Length 1: every word is both first (and last).
        launch(1, 3);
        collect("t3", 1, 3, 1'b0, fc, lc);
        check("t3 back to back", 32'(lc - fc), 32'd3);

        // Out-of-range lengths are ignored.
        seen = 1'b0;
        launch(0, 0);
        repeat (4) begin seen |= vld | busy | done; tick(); end
        check("len 0 ignored", 32'(seen), 32'd0);
        seen = 1'b0;
        launch(129, 0);
        repeat (4) begin seen |= vld | busy | done; tick(); end
        check("len 129 ignored", 32'(seen), 32'd0);

        // Write while busy is dropped and flagged.
        rdy = 1'b0;
        launch(4, 0);
        wr_en = 1'b1; wr_addr = ADDR_W'(1); wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        check("wr_err pulse", 32'(wr_err), 32'd1);
        tick();
        check("wr_err one cycle", 32'(wr_err), 32'd0);
        collect("t4 drain", 4, 0, 1'b0, fc, lc);
        launch(4, 0);
        collect("t4 replay", 4, 0, 1'b0, fc, lc);

        // Reset after the second transfer while stalled.
        rdy = 1'b1;
        launch(4, 1);
        tick();
        tick();
        tick();
        check("t5 third word pending", stage_1_data, BASE + 32'd2);
        rdy   = 1'b0;
        reset = 1'b1;
        tick();
        check("t5 vld after reset", 32'(vld), 32'd0);
        check("t5 busy after reset", 32'(busy), 32'd0);
        reset = 1'b0;
        seen  = done;
        repeat (3) begin tick(); seen |= done | vld; end
        check("t5 no done/vld after reset", 32'(seen), 32'd0);
        rdy = 1'b1;
        launch(4, 0);
        collect("t5 fresh", 4, 0, 1'b0, fc, lc);
        check("t5 fresh latency", 32'(fc), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
